// File: rtl/stepper_pkg.sv
// rtl/stepper_pkg.sv - shared types, coil phase table and index stepping for the stepper driver
//
// Contents:
//   state_t   : move FSM states (IDLE, RUN)
//   SMC_OFF   : de-energised coil pattern
//   PHASE_LUT : 8-entry half-step coil table; full-step uses the even entries
//   next_idx  : phase index advance, mod 8

package stepper_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [3:0] SMC_OFF = 4'b0000;

    localparam logic [3:0] PHASE_LUT [0:7] = '{
        4'b1001, 4'b0001, 4'b0011, 4'b0010,
        4'b0110, 4'b0100, 4'b1100, 4'b1000
    };

    // Full-step moves always land on an even index, so a move that starts
    // from an odd index (left by a half-step move) only travels one entry.
    function automatic logic [2:0] next_idx(input logic [2:0] idx,
                                            input logic       dir,
                                            input logic       half);
        logic [2:0] r;
        if (half)
            r = dir ? (idx + 3'd1) : (idx - 3'd1);
        else if (dir)
            r = (idx | 3'd1) + 3'd1;
        else
            r = (idx - 3'd1) & 3'b110;
        return r;
    endfunction

endpackage

// File: rtl/stepper_move_ctrl_step_tick_gen.sv
// rtl/stepper_move_ctrl_step_tick_gen.sv - step-rate prescaler emitting a one-cycle tick
//
// Module step_tick_gen
//   clk    in   1      system clock
//   reset  in   1      asynchronous active-high reset
//   clr    in   1      synchronous clear of the prescaler count
//   en     in   1      count enable
//   period in   DIV_W  clocks per tick; 0 behaves as 1
//   tick   out  1      high while count == max(period,1)-1 and en

module step_tick_gen #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic [DIV_W-1:0] period,
    output logic             tick
);

    logic [DIV_W-1:0] count;
    logic [DIV_W-1:0] last_cnt;

    assign last_cnt = (period == '0) ? '0 : (period - DIV_W'(1));
    assign tick     = en && (count == last_cnt);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (en)
            count <= tick ? '0 : (count + DIV_W'(1));
    end

endmodule

// File: rtl/stepper_move_ctrl.sv
// rtl/stepper_move_ctrl.sv - 4-coil unipolar stepper move controller (full/half step)
//
// Optional feature macro: POS_CNT_EN (adds the signed position counter and pos port)
//
// Ports:
//   clk        in   1      system clock
//   reset      in   1      asynchronous active-high reset
//   start      in   1      move request, sampled in IDLE only
//   dir        in   1      1 = forward, 0 = reverse (latched at start)
//   half_step  in   1      1 = 8-phase, 0 = 4-phase (latched at start)
//   steps      in   CNT_W  step count (latched at start)
//   period     in   DIV_W  clocks per step, 0 acts as 1 (latched at start)
//   abort      in   1      stop the current move, no done pulse
//   busy       out  1      high while a move runs
//   done       out  1      one-cycle completion pulse
//   SMC        out  4      registered coil pattern
//   pos        out  POS_W  signed position in half-step units (POS_CNT_EN only)

module stepper_move_ctrl
    import stepper_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter int DIV_W = 16,
    parameter int POS_W = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    dir,
    input  logic                    half_step,
    input  logic [CNT_W-1:0]        steps,
    input  logic [DIV_W-1:0]        period,
    input  logic                    abort,
    output logic                    busy,
    output logic                    done,
    output logic [3:0]              SMC
`ifdef POS_CNT_EN
    ,
    output logic signed [POS_W-1:0] pos
`endif
);

    state_t           state;
    state_t           state_nx;
    logic             dir_q;
    logic             half_q;
    logic [CNT_W-1:0] remaining;
    logic [DIV_W-1:0] period_q;
    logic [2:0]       idx;
    logic [2:0]       idx_nx;
    logic             tick;
    logic             go;
    logic             zero_req;
    logic             step;
    logic             last;

    // abort has priority over start, even while idle
    assign go       = (state == IDLE) && start && !abort && (steps != '0);
    assign zero_req = (state == IDLE) && start && !abort && (steps == '0);
    assign step     = (state == RUN) && tick && !abort;
    assign last     = step && (remaining == CNT_W'(1));
    assign idx_nx   = next_idx(idx, dir_q, half_q);
    assign busy     = (state == RUN);

    step_tick_gen #(.DIV_W(DIV_W)) u_tick (
        .clk    (clk),
        .reset  (reset),
        .clr    (state == IDLE),
        .en     (state == RUN),
        .period (period_q),
        .tick   (tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (go) state_nx = RUN;
            RUN:  if (abort || last) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // SMC is only written on a step, so it stays de-energised until the
    // first step after reset and holds torque afterwards.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dir_q     <= 1'b0;
            half_q    <= 1'b0;
            remaining <= '0;
            period_q  <= '0;
            idx       <= 3'd0;
            SMC       <= SMC_OFF;
            done      <= 1'b0;
        end else begin
            done <= zero_req || last;
            if (go) begin
                dir_q     <= dir;
                half_q    <= half_step;
                remaining <= steps;
                period_q  <= period;
            end
            if (step) begin
                idx       <= idx_nx;
                remaining <= remaining - CNT_W'(1);
                SMC       <= PHASE_LUT[idx_nx];
            end
        end
    end

`ifdef POS_CNT_EN
    logic signed [POS_W-1:0] delta;

    // a full step from an odd index only moves one half-step unit
    assign delta = (half_q || idx[0]) ? POS_W'(1) : POS_W'(2);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            pos <= '0;
        else if (step)
            pos <= dir_q ? (pos + delta) : (pos - delta);
    end
`endif

endmodule

// File: tb/tb_stepper_move_ctrl.sv
// tb/tb_stepper_move_ctrl.sv - directed self-checking bench for stepper_move_ctrl

module tb_stepper_move_ctrl;

    localparam int CNT_W = 16;
    localparam int DIV_W = 16;
    localparam int POS_W = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             dir;
    logic             half_step;
    logic [CNT_W-1:0] steps;
    logic [DIV_W-1:0] period;
    logic             abort;
    logic             busy;
    logic             done;
    logic [3:0]       smc;
`ifdef POS_CNT_EN
    logic signed [POS_W-1:0] pos;
`endif

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    stepper_move_ctrl #(.CNT_W(CNT_W), .DIV_W(DIV_W), .POS_W(POS_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .dir       (dir),
        .half_step (half_step),
        .steps     (steps),
        .period    (period),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .SMC       (smc)
`ifdef POS_CNT_EN
        ,
        .pos       (pos)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // start cycle is cycle 0; returns in cycle 1
    task automatic launch(input int s, input int p, input logic d, input logic h);
        start     = 1'b1;
        steps     = CNT_W'(s);
        period    = DIV_W'(p);
        dir       = d;
        half_step = h;
        cyc       = 0;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) tick();
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; dir = 1'b0; half_step = 1'b0;
        steps = '0; period = '0; abort = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_smc", smc, 4'b0000);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        reset = 1'b0;

        // idle 10 clocks, abort in idle must do nothing
        abort = 1'b1;
        repeat (10) tick();
        abort = 1'b0;
        chk("idle_smc", smc, 4'b0000);
        chk("idle_busy", busy, 1'b0);
        chk("idle_done", done, 1'b0);

        // full-step forward, 4 steps, period 3: idx 0->2->4->6->0
        launch(4, 3, 1'b1, 1'b0);
        chk("t2_busy1", busy, 1'b1);
        wait_to(3);  chk("t2_c3_off", smc, 4'b0000);
        wait_to(4);  chk("t2_c4", smc, 4'b0011);
        wait_to(6);  chk("t2_c6_hold", smc, 4'b0011);
        wait_to(7);  chk("t2_c7", smc, 4'b0110);
        wait_to(10); chk("t2_c10", smc, 4'b1100);
        wait_to(12); chk("t2_c12_busy", busy, 1'b1);
                     chk("t2_c12_done", done, 1'b0);
        wait_to(13); chk("t2_c13", smc, 4'b1001);
                     chk("t2_c13_busy", busy, 1'b0);
                     chk("t2_c13_done", done, 1'b1);
`ifdef POS_CNT_EN
                     chk("t2_pos", pos, 32'd8);
`endif
        wait_to(14); chk("t2_c14_done", done, 1'b0);

        // half-step reverse, 3 steps, period 1: idx 0->7->6->5
        launch(3, 1, 1'b0, 1'b1);
        wait_to(2); chk("t3_c2", smc, 4'b1000);
        wait_to(3); chk("t3_c3", smc, 4'b1100);
        wait_to(4); chk("t3_c4", smc, 4'b0100);
                    chk("t3_done", done, 1'b1);
                    chk("t3_busy", busy, 1'b0);
`ifdef POS_CNT_EN
                    chk("t3_pos", pos, 32'd5);
`endif

        // half-step forward 4 to idx1, then full forward 2 from odd idx
        launch(4, 2, 1'b1, 1'b1);
        wait_to(9); chk("t4_half_end", smc, 4'b0001);
                    chk("t4_half_done", done, 1'b1);
`ifdef POS_CNT_EN
                    chk("t4_pos_a", pos, 32'd9);
`endif
        launch(2, 1, 1'b1, 1'b0);
        wait_to(2); chk("t4_idx2", smc, 4'b0011);
        wait_to(3); chk("t4_idx4", smc, 4'b0110);
                    chk("t4_done", done, 1'b1);
`ifdef POS_CNT_EN
                    chk("t4_pos_b", pos, 32'd12);
`endif

        // long move, abort on the third step tick; start while busy ignored
        launch(100, 5, 1'b1, 1'b0);
        wait_to(6);  chk("t5_c6", smc, 4'b1100);
        wait_to(7);
        start = 1'b1; steps = '0;
        tick();
        start = 1'b0;
        chk("t5_ign_done", done, 1'b0);
        chk("t5_ign_busy", busy, 1'b1);
        wait_to(11); chk("t5_c11", smc, 4'b1001);
        wait_to(15);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t5_abort_busy", busy, 1'b0);
        chk("t5_abort_smc", smc, 4'b1001);
        chk("t5_abort_done", done, 1'b0);
        tick();
        chk("t5_after_done", done, 1'b0);
        chk("t5_after_smc", smc, 4'b1001);
`ifdef POS_CNT_EN
        chk("t5_pos", pos, 32'd16);
`endif

        // zero-step request: done pulse, no motion
        launch(0, 3, 1'b1, 1'b0);
        chk("t6_zero_done", done, 1'b1);
        chk("t6_zero_busy", busy, 1'b0);
        chk("t6_zero_smc", smc, 4'b1001);
        tick();
        chk("t6_zero_done2", done, 1'b0);

        // abort together with start in idle: no move
        abort = 1'b1;
        launch(4, 1, 1'b1, 1'b0);
        chk("t6_ab_busy", busy, 1'b0);
        chk("t6_ab_done", done, 1'b0);
        abort = 1'b0;
        tick();
        chk("t6_ab_smc", smc, 4'b1001);

        // period 0 acts as period 1
        launch(1, 0, 1'b1, 1'b0);
        chk("t6_p0_busy", busy, 1'b1);
        tick();
        chk("t6_p0_smc", smc, 4'b0011);
        chk("t6_p0_done", done, 1'b1);
`ifdef POS_CNT_EN
        chk("t6_p0_pos", pos, 32'd18);
`endif

        // asynchronous reset mid-move, checked before the next clock edge
        launch(50, 2, 1'b1, 1'b0);
        wait_to(5);
        chk("t6_run_busy", busy, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        chk("t6_arst_smc", smc, 4'b0000);
        chk("t6_arst_busy", busy, 1'b0);
`ifdef POS_CNT_EN
        chk("t6_arst_pos", pos, 32'd0);
`endif
        #2;
        reset = 1'b0;
        tick();
        chk("t6_post_busy", busy, 1'b0);
        chk("t6_post_smc", smc, 4'b0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
